// File: rtl/mem_responder.sv
// mem_responder: single-port word-organised memory behind a valid/ready handshake.
// One request is latched in IDLE. The block then inserts WAIT_CYCLES wait states and performs
// either a read or a byte-masked write. Completion is a one-cycle mem_ready pulse, and mem_err
// is qualified by mem_ready.
//
// Ports:
//   clk        - clock, rising edge
//   resetn     - asynchronous active-low reset
//   mem_valid  - request present (sampled only in IDLE)
//   mem_instr  - request is an instruction fetch
//   mem_addr   - byte address
//   mem_wdata  - write data, byte lanes aligned to the word
//   mem_wstrb  - byte write enables, 0 = read
//   mem_ready  - one-cycle completion pulse
//   mem_rdata  - read data, valid while mem_ready=1, held otherwise
//   mem_err    - illegal access flag, qualified by mem_ready
module mem_responder #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_instr;
    logic        r_ready, w_ready_next;
    logic        r_err, w_err_next;
    logic [31:0] r_rdata, w_rdata_next;
    logic        w_latch;

    logic [31:0] r_mem [MEM_WORDS];

    // Decode of the latched request. Addresses below the base wrap to large indices, so they
    // fail the range check.
    logic [31:0]   w_offset;
    logic [31:0]   w_index;
    logic          w_in_range;
    logic          w_aligned;
    logic          w_err;
    logic [AW-1:0] w_word_idx;
    logic [31:0]   w_rd_word;
    logic          w_do_write;

    assign w_offset   = r_addr - ADDR_BASE;
    assign w_index    = {2'b00, w_offset[31:2]};
    assign w_in_range = (w_index < MEM_WORDS);
    assign w_aligned  = (w_offset[1:0] == 2'b00) && (r_addr[1:0] == 2'b00);
    assign w_err      = !w_in_range || !w_aligned || (r_instr && (r_wstrb != 4'b0000));
    assign w_word_idx = w_index[AW-1:0];
    assign w_rd_word  = r_mem[w_word_idx];
    assign w_do_write = (r_state == StWait) && (r_cnt == 4'd0) && !w_err &&
                        (r_wstrb != 4'b0000);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_ready_next = 1'b0;
        w_err_next   = 1'b0;
        w_rdata_next = r_rdata;
        w_latch      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (mem_valid) begin
                    w_latch      = 1'b1;
                    w_cnt_next   = WAIT_LOAD;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_ready_next = 1'b1;
                    w_state_next = StResp;
                    if (w_err) begin
                        w_err_next   = 1'b1;
                        w_rdata_next = '0;
                    end else if (r_wstrb == 4'b0000) begin
                        w_rdata_next = w_rd_word;
                    end
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_instr <= 1'b0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_ready <= w_ready_next;
            r_err   <= w_err_next;
            r_rdata <= w_rdata_next;
            if (w_latch) begin
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_wstrb <= mem_wstrb;
                r_instr <= mem_instr;
            end
        end
    end

    // The array is not reset. While resetn is low the state is IDLE, so an abandoned write
    // never reaches the array.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (r_wstrb[k]) begin
                    r_mem[w_word_idx][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    assign mem_ready = r_ready;
    assign mem_err   = r_err;
    assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid_a, valid_b;
    logic        ready_a, ready_b;
    logic        err_a, err_b;
    logic [31:0] rdata_a, rdata_b;

    int errors = 0;
    int checks = 0;

    int          lat;
    logic [31:0] rd;
    logic        er;

    int pulses;
    int first_idx;
    int last_idx;
    int bad_b2b;
    int bad_gap;
    int bad_data;
    bit prev_ready;
    bit seen;

    always #5 clk = ~clk;

    // DUT A: default geometry, two wait states.
    mem_responder #(
        .MEM_WORDS  (1024),
        .ADDR_BASE  (32'h0000_0000),
        .WAIT_CYCLES(2)
    ) u_dut_a (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(valid_a),
        .mem_instr(instr),
        .mem_addr (addr),
        .mem_wdata(wdata),
        .mem_wstrb(wstrb),
        .mem_ready(ready_a),
        .mem_rdata(rdata_a),
        .mem_err  (err_a)
    );

    // DUT B: zero wait states, non-zero base, smaller array.
    mem_responder #(
        .MEM_WORDS  (256),
        .ADDR_BASE  (32'h0000_8000),
        .WAIT_CYCLES(0)
    ) u_dut_b (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(valid_b),
        .mem_instr(instr),
        .mem_addr (addr),
        .mem_wdata(wdata),
        .mem_wstrb(wstrb),
        .mem_ready(ready_b),
        .mem_rdata(rdata_b),
        .mem_err  (err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for the ready pulse. The call starts and ends #1 after a
    // rising edge with the DUT in IDLE. o_lat counts edges from the accept edge to the edge
    // that raised mem_ready, and is -1 on timeout.
    task automatic txn(input bit sel_b, input logic ins, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output int o_lat, output logic [31:0] o_rd, output logic o_er);
        instr = ins;
        addr  = a;
        wdata = d;
        wstrb = s;
        if (sel_b) valid_b = 1'b1;
        else       valid_a = 1'b1;
        o_lat = -1;
        o_rd  = 'x;
        o_er  = 1'bx;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if ((sel_b ? ready_b : ready_a) === 1'b1) begin
                o_lat = n;
                o_rd  = sel_b ? rdata_b : rdata_a;
                o_er  = sel_b ? err_b : err_a;
                break;
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn  = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        instr   = 1'b0;
        addr    = '0;
        wdata   = '0;
        wstrb   = '0;
        #12;
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_err_a",   32'(err_a),   32'd0);
        check("rst_rdata_a", rdata_a,      32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        check("rst_rdata_b", rdata_b,      32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Full-word write then read-back.
        txn(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, lat, rd, er);
        check("wr10_lat",   32'(lat), 32'd3);
        check("wr10_err",   32'(er),  32'd0);
        check("wr10_rdata", rd,       32'd0);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
        check("rd10_lat",   32'(lat), 32'd3);
        check("rd10_err",   32'(er),  32'd0);
        check("rd10_rdata", rd,       32'hDEADBEEF);
        check("ready_low_after", 32'(ready_a), 32'd0);

        // Byte merge with strobes 0101.
        txn(1'b0, 1'b0, 32'h20, 32'h11223344, 4'b1111, lat, rd, er);
        txn(1'b0, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, er);
        check("merge_wr_rdata_held", rd, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, er);
        check("merge_rdata", rd, 32'h11BB33DD);

        // Error cases.
        txn(1'b0, 1'b0, 32'h0, 32'h01020304, 4'b1111, lat, rd, er);
        txn(1'b0, 1'b0, 32'h22, 32'h0, 4'b0000, lat, rd, er);
        check("misalign_lat",   32'(lat), 32'd3);
        check("misalign_err",   32'(er),  32'd1);
        check("misalign_rdata", rd,       32'd0);
        check("err_clears",     32'(err_a), 32'd0);
        txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'b0000, lat, rd, er);
        check("oor_err",   32'(er), 32'd1);
        check("oor_rdata", rd,      32'd0);
        txn(1'b0, 1'b0, 32'hFFC, 32'h0, 4'b0000, lat, rd, er);
        check("lastword_a_err", 32'(er), 32'd0);
        txn(1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0001, lat, rd, er);
        check("fetchwr_err",   32'(er), 32'd1);
        check("fetchwr_rdata", rd,      32'd0);
        txn(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, lat, rd, er);
        check("addr0_unchanged", rd,      32'h01020304);
        check("addr0_err",       32'(er), 32'd0);
        txn(1'b0, 1'b1, 32'h10, 32'h0, 4'b0000, lat, rd, er);
        check("fetch_rd_rdata", rd,      32'hDEADBEEF);
        check("fetch_rd_err",   32'(er), 32'd0);

        // Back-to-back: mem_valid held high with a fixed read.
        instr      = 1'b0;
        addr       = 32'h10;
        wstrb      = 4'b0000;
        valid_a    = 1'b1;
        pulses     = 0;
        first_idx  = -1;
        last_idx   = -1;
        bad_b2b    = 0;
        bad_gap    = 0;
        bad_data   = 0;
        prev_ready = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (ready_a === 1'b1) begin
                if (prev_ready) bad_b2b++;
                if (last_idx >= 0 && (n - last_idx) != 5) bad_gap++;
                if (first_idx < 0) first_idx = n;
                if (rdata_a !== 32'hDEADBEEF) bad_data++;
                pulses++;
                last_idx = n;
            end
            prev_ready = (ready_a === 1'b1);
        end
        valid_a = 1'b0;
        check("hs_pulses",    32'(pulses),    32'd5);
        check("hs_first",     32'(first_idx), 32'd3);
        check("hs_gap",       32'(bad_gap),   32'd0);
        check("hs_b2b",       32'(bad_b2b),   32'd0);
        check("hs_data",      32'(bad_data),  32'd0);
        @(posedge clk);
        #1;

        // Reset during WAIT abandons the write.
        txn(1'b0, 1'b0, 32'h30, 32'h0, 4'b1111, lat, rd, er);
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, er);
        check("pre_rst_rdata", rdata_a, 32'hDEADBEEF);
        instr   = 1'b0;
        addr    = 32'h30;
        wdata   = 32'hCAFEF00D;
        wstrb   = 4'b1111;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("rstw_ready", 32'(ready_a), 32'd0);
        check("rstw_err",   32'(err_a),   32'd0);
        check("rstw_rdata", rdata_a,      32'd0);
        #4;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rstw_idle_ready", 32'(ready_a), 32'd0);
        txn(1'b0, 1'b0, 32'h30, 32'h0, 4'b0000, lat, rd, er);
        check("rstw_rd_lat",   32'(lat), 32'd3);
        check("rstw_rd30",     rd,       32'h00000000);
        check("rstw_rd30_err", 32'(er),  32'd0);

        // Reset during RESP drops mem_ready immediately.
        addr    = 32'h10;
        wstrb   = 4'b0000;
        valid_a = 1'b1;
        seen    = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (ready_a === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        valid_a = 1'b0;
        check("resp_seen",  32'(seen),    32'd1);
        check("resp_rdata", rdata_a,      32'hDEADBEEF);
        resetn = 1'b0;
        #1;
        check("rstr_ready", 32'(ready_a), 32'd0);
        check("rstr_rdata", rdata_a,      32'd0);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait build, non-zero base.
        txn(1'b1, 1'b0, 32'h83FC, 32'h5A5A5A5A, 4'b1111, lat, rd, er);
        check("b_wr_lat", 32'(lat), 32'd1);
        check("b_wr_err", 32'(er),  32'd0);
        txn(1'b1, 1'b0, 32'h83FC, 32'h0, 4'b0000, lat, rd, er);
        check("b_last_lat",   32'(lat), 32'd1);
        check("b_last_rdata", rd,       32'h5A5A5A5A);
        check("b_last_err",   32'(er),  32'd0);
        txn(1'b1, 1'b0, 32'h8400, 32'h0, 4'b0000, lat, rd, er);
        check("b_oor_err",   32'(er), 32'd1);
        check("b_oor_rdata", rd,      32'd0);
        txn(1'b1, 1'b0, 32'h7FFC, 32'h0, 4'b0000, lat, rd, er);
        check("b_below_err", 32'(er), 32'd1);
        txn(1'b1, 1'b0, 32'h8000, 32'h12345678, 4'b1111, lat, rd, er);
        txn(1'b1, 1'b0, 32'h8000, 32'h0, 4'b0000, lat, rd, er);
        check("b_base_rdata", rd,      32'h12345678);
        check("b_base_err",   32'(er), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Single-port word-organised memory that answers the core's native memory interface (mem_addr/mem_wdata/mem_wstrb/mem_rdata/mem_instr) and adds a mem_valid/mem_ready handshake. It latches one request, waits a programmable number of cycles, then performs the read or the byte-masked write. It signals completion with a one-cycle mem_ready pulse, plus mem_err for illegal accesses. It serves both instruction fetch and load/store traffic.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the array
ADDR_BASE, 32'h0000_0000, byte address of word 0
WAIT_CYCLES, 2, extra wait states inserted before every access (0..15)

Ports:
clk  input  1  clock; all state changes on the rising edge
resetn  input  1  asynchronous active-low reset
mem_valid  input  1  request present; held high by the initiator until mem_ready is seen
mem_instr  input  1  request is an instruction fetch
mem_addr  input  32  byte address of the request
mem_wdata  input  32  write data, byte lanes aligned to the word
mem_wstrb  input  4  byte write enables; 0 = read
mem_ready  output  1  one-cycle completion pulse
mem_rdata  output  32  read data; valid while mem_ready=1
mem_err  output  1  error flag, qualified by mem_ready

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; mem_ready=0, mem_err=0, mem_rdata=0, wait counter=0, latched request cleared. Array contents are not cleared. A request in flight is abandoned and no write occurs.
- FSM states IDLE, WAIT, RESP:
  - IDLE: on an edge with mem_valid=1, latch addr/wdata/wstrb/instr, load counter=WAIT_CYCLES, go to WAIT. Otherwise stay in IDLE.
  - WAIT: if counter!=0, decrement and stay. If counter==0, perform the access, register mem_ready=1 and the results, go to RESP.
  - RESP: mem_ready=1 for exactly this cycle. At the next edge: mem_ready=0, mem_err=0, go to IDLE.
- Latency: request sampled at edge E0 gives mem_ready high from edge E0+WAIT_CYCLES+1 for one cycle. The minimum request-to-request spacing is WAIT_CYCLES+3 edges.
- Request fields are ignored after latching; changing them mid-transaction has no effect.
- mem_valid is sampled only in IDLE. The initiator drops mem_valid or presents a new request after seeing mem_ready. A request still asserted at the IDLE edge is treated as a new request.
- Address decode: index = (latched_addr - ADDR_BASE) >> 2, using 32-bit unsigned subtraction, so addresses below the base wrap to large values and count as out of range.
  - In range: index < MEM_WORDS.
  - Aligned: addr[1:0]==0.
- Error conditions: out of range, misaligned, or mem_instr=1 with wstrb!=0.
  - On error: no array write, mem_err=1, mem_rdata=0 during the ready cycle.
- Read (wstrb==0, no error): mem_rdata = array[index], mem_err=0.
- Write (wstrb!=0, no error): for each set bit k, byte k of array[index] = wdata[8k+7:8k]; other bytes are unchanged. Any strobe pattern is legal. mem_rdata keeps its previous value; mem_err=0.
- mem_rdata holds its value outside ready cycles until the next completed read or error.
- Boundaries:
  - Last word (index=MEM_WORDS-1) is legal.
  - index=MEM_WORDS gives an error.
  - WAIT_CYCLES=0 gives one-edge latency, E0 to ready at E0+1.
  - Reset asserted during RESP forces mem_ready low immediately.

Test Plan:
- WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 1111, then read addr 0x10. Required: mem_ready pulses 3 edges after each accept, second rdata=0xDEADBEEF, mem_err=0.
- Byte merge: preload 0x11223344 at 0x20, write wdata 0xAABBCCDD wstrb 0101, read back. Required: 0x11BB33DD.
- Errors: read addr 0x22 (misaligned); read ADDR_BASE+4*MEM_WORDS; fetch (mem_instr=1) with wstrb=0001 to 0x0. Required: each gives mem_ready=1, mem_err=1, rdata=0, and the array at 0x0 is unchanged.
- Handshake: hold mem_valid high continuously with a fixed read request. Required: exactly one completion every WAIT_CYCLES+3 edges, mem_ready never high two consecutive cycles.
- Reset mid-operation: accept a write to 0x30 of 0xCAFEF00D (old value 0x0), pull resetn low during WAIT for half a cycle. Required: mem_ready, mem_err, and mem_rdata drop to 0 asynchronously, state IDLE, subsequent read of 0x30 returns 0x00000000.
- WAIT_CYCLES=0 build: read last word (index MEM_WORDS-1, preloaded 0x5A5A5A5A). Required: ready one edge after accept, rdata=0x5A5A5A5A, mem_err=0.
